// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan controller and its environment: start/mask request,
// downstream mux select and sample input, and the valid/ready result handshake.
interface mux_scan_ctrl_if #(
  parameter int SELECTOR_SIZE = 2
);
  localparam int NCH = 2 ** SELECTOR_SIZE;

  logic                     start;
  logic [NCH-1:0]           channel_mask;
  logic                     MUX_IN;
  logic [SELECTOR_SIZE-1:0] selector;
  logic [NCH-1:0]           SCAN_DATA;
  logic                     scan_valid;
  logic                     scan_ready;
  logic                     busy;

  // master: the requester/consumer side; slave: the scan controller itself
  modport master (
    output start, channel_mask, MUX_IN, scan_ready,
    input  selector, SCAN_DATA, scan_valid, busy
  );

  modport slave (
    input  start, channel_mask, MUX_IN, scan_ready,
    output selector, SCAN_DATA, scan_valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a downstream 4:1 mux in ascending order, holding
// the selector for a settle time before each sample, then hands off the word.
module mux_scan_ctrl #(
  parameter int SELECTOR_SIZE = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mux_scan_ctrl_if.slave    bus
);
  localparam int NCH = 2 ** SELECTOR_SIZE;
  localparam logic [NCH-1:0] ONES = '1;
  localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

  state_t                   state_reg, state_next;
  logic [SELECTOR_SIZE-1:0] sel_reg, sel_next;
  logic [3:0]               cnt_reg, cnt_next;
  logic [NCH-1:0]           mask_reg, mask_next;
  logic [NCH-1:0]           shadow_reg, shadow_next;
  logic [NCH-1:0]           data_reg, data_next;
  logic                     valid_reg, valid_next;
  logic                     busy_reg, busy_next;

  logic [NCH-1:0]           hit;
  logic [NCH-1:0]           captured;
  logic [NCH-1:0]           above_sel;

  function automatic logic [SELECTOR_SIZE-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [SELECTOR_SIZE-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) r = SELECTOR_SIZE'(i);
    end
    return r;
  endfunction

  // Shadow word with the current mux sample merged into the selected bit
  for (genvar gi = 0; gi < NCH; gi++) begin : g_capture
    assign hit[gi]      = (sel_reg == SELECTOR_SIZE'(gi));
    assign captured[gi] = hit[gi] ? bus.MUX_IN : shadow_reg[gi];
  end

  // Enabled channels strictly above the one currently selected
  assign above_sel = mask_reg & ((ONES << sel_reg) << 1);

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    cnt_next    = cnt_reg;
    mask_next   = mask_reg;
    shadow_next = shadow_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        sel_next   = '0;
        if (bus.start && (|bus.channel_mask)) begin
          mask_next   = bus.channel_mask;
          shadow_next = '0;
          sel_next    = lowest_set(bus.channel_mask);
          cnt_next    = SETTLE_LOAD;
          state_next  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) state_next = SAMPLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      SAMPLE: begin
        shadow_next = captured;
        if (|above_sel) begin
          sel_next   = lowest_set(above_sel);
          cnt_next   = SETTLE_LOAD;
          state_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end else begin
          // disabled channels were never written, so they read back as 0
          data_next  = captured;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.scan_ready) begin
          valid_next = 1'b0;
          sel_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      cnt_reg    <= '0;
      mask_reg   <= '0;
      shadow_reg <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      cnt_reg    <= cnt_next;
      mask_reg   <= mask_next;
      shadow_reg <= shadow_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      busy_reg   <= busy_next;
    end
  end

  assign bus.selector   = sel_reg;
  assign bus.SCAN_DATA  = data_reg;
  assign bus.scan_valid = valid_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (settle 1, 2, 0) driven by directed
// and random scans, checked against a timeline model of the scan rules.
module tb_mux_scan_ctrl;
  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [2:0] ready_v;
  logic [3:0] mask_v [3];
  logic [3:0] data_v [3];
  logic [1:0] sel_v  [3];
  logic [3:0] sd_v   [3];
  logic [2:0] valid_v;
  logic [2:0] busy_v;
  logic [3:0] last_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 0;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mux_scan_ctrl_if #(.SELECTOR_SIZE(2)) bus ();
    mux_scan_ctrl #(
      .SELECTOR_SIZE(2),
      .SETTLE_CYCLES((gi == 0) ? 1 : (gi == 1) ? 2 : 0)
    ) dut (
      .clk   (clk),
      .reset (rst_v[gi]),
      .bus   (bus)
    );
    assign bus.start        = start_v[gi];
    assign bus.channel_mask = mask_v[gi];
    assign bus.scan_ready   = ready_v[gi];
    assign bus.MUX_IN       = data_v[gi][bus.selector];
    assign sel_v[gi]        = bus.selector;
    assign sd_v[gi]         = bus.SCAN_DATA;
    assign valid_v[gi]      = bus.scan_valid;
    assign busy_v[gi]       = bus.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int k, input logic [3:0] exp_data);
    check("idle_sel", sel_v[k], 0);
    check("idle_valid", valid_v[k], 0);
    check("idle_busy", busy_v[k], 0);
    check("idle_data", sd_v[k], exp_data);
  endtask

  // One scan on instance k. hold = extra cycles with scan_ready low after valid;
  // abort = pulse reset in the first valid cycle instead of consuming the result.
  task automatic run_scan(input int k, input logic [3:0] m, input logic [3:0] d,
                          input int hold, input bit abort);
    int s;
    int t;
    int ch[$];
    logic [3:0] exp_data;
    s = sc_of(k);
    for (int i = 0; i < 4; i++) if (m[i]) ch.push_back(i);
    exp_data = d & m;
    t = 1 + ch.size() * (s + 1);

    data_v[k]  = d;
    mask_v[k]  = m;
    start_v[k] = 1'b1;
    ready_v[k] = (hold == 0) && !abort;
    tick();
    start_v[k] = 1'b0;
    mask_v[k]  = 4'($urandom);
    for (int c = 1; c < t; c++) begin
      check("scan_sel", sel_v[k], ch[(c - 1) / (s + 1)]);
      check("scan_busy", busy_v[k], 1);
      check("scan_valid_early", valid_v[k], 0);
      check("scan_retain", sd_v[k], last_v[k]);
      start_v[k] = 1'($urandom_range(0, 1));
      tick();
    end
    check("valid_rise", valid_v[k], 1);
    check("result", sd_v[k], exp_data);
    check("hold_busy", busy_v[k], 1);

    if (abort) begin
      start_v[k] = 1'b0;
      rst_v[k]   = 1'b1;
      tick();
      rst_v[k]   = 1'b0;
      last_v[k]  = 4'b0000;
      check_idle(k, 4'b0000);
      $display("scan dut=%0d settle=%0d mask=%b data=%b aborted in hold", k, s, m, d);
      return;
    end

    for (int h = 0; h < hold; h++) begin
      start_v[k] = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", valid_v[k], 1);
      check("hold_data", sd_v[k], exp_data);
      check("hold_busy", busy_v[k], 1);
    end
    start_v[k] = 1'b0;
    ready_v[k] = 1'b1;
    tick();
    ready_v[k] = 1'b0;
    last_v[k]  = exp_data;
    check_idle(k, exp_data);
    $display("scan dut=%0d settle=%0d mask=%b data=%b result=%b hold=%0d latency=%0d",
             k, s, m, d, exp_data, hold, t);
  endtask

  initial begin
    rst_v   = 3'b111;
    start_v = 3'b000;
    ready_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      mask_v[k] = 4'b0000;
      data_v[k] = 4'b0000;
      last_v[k] = 4'b0000;
    end
    tick();
    tick();
    // reset dominates start and ready
    start_v = 3'b111;
    ready_v = 3'b111;
    for (int k = 0; k < 3; k++) mask_v[k] = 4'b1111;
    tick();
    for (int k = 0; k < 3; k++) check_idle(k, 4'b0000);
    rst_v   = 3'b000;
    start_v = 3'b000;
    ready_v = 3'b000;
    tick();

    // Directed: full mask, settle 1; selector 0..3, valid in cycle 9
    run_scan(0, 4'b1111, 4'b1010, 0, 1'b0);
    // Sparse mask, settle 2; only channels 0 and 2, valid in cycle 7
    run_scan(1, 4'b0101, 4'b1111, 0, 1'b0);
    // Settle 0, single top channel; valid in cycle 2
    run_scan(2, 4'b1000, 4'b1000, 0, 1'b0);
    // Backpressure: ready low for 5 cycles in hold, start pulses ignored
    run_scan(0, 4'b0110, 4'b0100, 5, 1'b0);

    // Empty mask is ignored
    start_v[1] = 1'b1;
    mask_v[1]  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle(1, last_v[1]);
    end
    start_v[1] = 1'b0;

    // Reset in the settle phase of channel 1
    data_v[0]  = 4'b1111;
    mask_v[0]  = 4'b1111;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    check("pre_reset_sel", sel_v[0], 1);
    check("pre_reset_busy", busy_v[0], 1);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0]  = 1'b0;
    last_v[0] = 4'b0000;
    check_idle(0, 4'b0000);
    $display("scan dut=0 settle=1 mask=1111 aborted in settle of channel 1");
    run_scan(0, 4'b1011, 4'b0011, 1, 1'b0);

    // Reset during hold drops the result
    run_scan(1, 4'b1110, 4'b0110, 0, 1'b1);

    // Random scans across all three settle settings
    for (int n = 0; n < 40; n++) begin
      run_scan($urandom_range(0, 2), 4'($urandom_range(1, 15)), 4'($urandom),
               $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
